// File: rtl/pe_ctrl_pkg.sv
// Shared types and helpers for the PE run controller.
package pe_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } pe_ctrl_state_t;

    localparam int PIPE_LAT_DEF = 3;

    // A zero or oversized request means "process the whole buffer".
    function automatic int clamp_len(input int len, input int data_num);
        return ((len == 0) || (len > data_num)) ? data_num : len;
    endfunction

endpackage

// File: rtl/pe_run_ctrl_if.sv
// Host command, buffer access and error-status bundle of the PE run controller.
interface pe_run_ctrl_if #(
    parameter int DATA_NUM  = 16,
    parameter int ERR_CNT_W = 8,
    parameter int ADDR_W    = $clog2(DATA_NUM)
);
    logic                 start_i;
    logic                 abort_i;
    logic [ADDR_W:0]      len_i;
    logic                 err1_i;
    logic                 err2_i;
    logic                 rd_en_o;
    logic [ADDR_W-1:0]    rd_addr_o;
    logic                 wb_en_o;
    logic [ADDR_W-1:0]    wb_addr_o;
    logic                 busy_o;
    logic                 done_o;
    logic [ERR_CNT_W-1:0] err1_cnt_o;
    logic [ERR_CNT_W-1:0] err2_cnt_o;
    logic                 first_err_vld_o;
    logic [ADDR_W-1:0]    first_err_addr_o;

    modport master (
        output start_i, abort_i, len_i, err1_i, err2_i,
        input  rd_en_o, rd_addr_o, wb_en_o, wb_addr_o, busy_o, done_o,
        input  err1_cnt_o, err2_cnt_o, first_err_vld_o, first_err_addr_o
    );

    modport slave (
        input  start_i, abort_i, len_i, err1_i, err2_i,
        output rd_en_o, rd_addr_o, wb_en_o, wb_addr_o, busy_o, done_o,
        output err1_cnt_o, err2_cnt_o, first_err_vld_o, first_err_addr_o
    );
endinterface

// File: rtl/pe_vld_shift.sv
// Valid delay line tracking entries in flight through the PE pipeline.
module pe_vld_shift #(
    parameter int PIPE_LAT = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_i,
    input  logic                vld_i,
    output logic [PIPE_LAT-1:0] vld_o
);
    logic [PIPE_LAT-1:0] vld_q, vld_d;

    always_comb begin
        vld_d = '0;
        if (!flush_i) begin
            vld_d[0] = vld_i;
            for (int i = 1; i < PIPE_LAT; i++) begin
                vld_d[i] = vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_q <= '0;
        else     vld_q <= vld_d;
    end

    assign vld_o = vld_q;
endmodule

// File: rtl/pe_run_ctrl.sv
// Run sequencer: issues buffer reads, tracks in-flight entries, drives write-back and error statistics.
//   state | meaning
//   IDLE  | waiting for start, results held
//   ISSUE | one read per cycle until the last address
//   DRAIN | waiting for in-flight entries to write back
//   DONE  | single done pulse cycle
module pe_run_ctrl
    import pe_ctrl_pkg::*;
#(
    parameter int DATA_NUM  = 16,
    parameter int ADDR_W    = $clog2(DATA_NUM),
    parameter int PIPE_LAT  = PIPE_LAT_DEF,
    parameter int ERR_CNT_W = 8
) (
    input logic        clk,
    input logic        rst,
    pe_run_ctrl_if.slave bus
);
    localparam logic [PIPE_LAT-1:0] TAP_MASK = PIPE_LAT'(1) << (PIPE_LAT - 1);

    pe_ctrl_state_t       state_q, state_d;
    logic                 rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]    rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]    rem_q, rem_d;
    logic [ADDR_W-1:0]    wb_addr_q, wb_addr_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [ERR_CNT_W-1:0] err1_cnt_q, err1_cnt_d;
    logic [ERR_CNT_W-1:0] err2_cnt_q, err2_cnt_d;
    logic                 fe_vld_q, fe_vld_d;
    logic [ADDR_W-1:0]    fe_addr_q, fe_addr_d;

    logic [PIPE_LAT-1:0]  vld;
    logic [ADDR_W:0]      len_c;
    logic                 wb_en, in_flight, start_ok, abort_run, last_issue, pend_after;

    pe_vld_shift #(.PIPE_LAT(PIPE_LAT)) u_vld_shift (
        .clk     (clk),
        .rst     (rst),
        .flush_i (abort_run),
        .vld_i   (rd_en_q),
        .vld_o   (vld)
    );

    assign len_c      = (ADDR_W+1)'(clamp_len(int'(bus.len_i), DATA_NUM));
    assign wb_en      = vld[PIPE_LAT-1];
    assign in_flight  = |vld;
    assign start_ok   = (state_q == IDLE) && bus.start_i && !bus.abort_i;
    assign abort_run  = (state_q != IDLE) && bus.abort_i;
    assign last_issue = rd_en_q && (rem_q == '0);
    // Anything still in flight after this edge: the read being issued now or a non-tap stage.
    assign pend_after = rd_en_q || (|(vld & ~TAP_MASK));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok)    state_d = ISSUE;
            ISSUE:   if (last_issue)  state_d = DRAIN;
            DRAIN:   if (!pend_after) state_d = DONE;
            DONE:                     state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
        if (abort_run) state_d = IDLE;
    end

    always_comb begin
        rd_en_d    = (state_d == ISSUE);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
        rd_addr_d  = rd_addr_q;
        rem_d      = rem_q;
        wb_addr_d  = wb_addr_q;
        err1_cnt_d = err1_cnt_q;
        err2_cnt_d = err2_cnt_q;
        fe_vld_d   = fe_vld_q;
        fe_addr_d  = fe_addr_q;
        if (start_ok) begin
            rd_addr_d  = '0;
            rem_d      = ADDR_W'(len_c - 1'b1);
            wb_addr_d  = '0;
            err1_cnt_d = '0;
            err2_cnt_d = '0;
            fe_vld_d   = 1'b0;
            fe_addr_d  = '0;
        end else if (!abort_run) begin
            if (rd_en_q && !last_issue) begin
                rd_addr_d = rd_addr_q + 1'b1;
                rem_d     = rem_q - 1'b1;
            end
            if (wb_en) wb_addr_d = wb_addr_q + 1'b1;
            if (in_flight) begin
                if (bus.err1_i && (err1_cnt_q != '1)) err1_cnt_d = err1_cnt_q + 1'b1;
                if (bus.err2_i && (err2_cnt_q != '1)) err2_cnt_d = err2_cnt_q + 1'b1;
                if ((bus.err1_i || bus.err2_i) && !fe_vld_q) begin
                    fe_vld_d  = 1'b1;
                    fe_addr_d = wb_addr_q;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            rem_q      <= '0;
            wb_addr_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err1_cnt_q <= '0;
            err2_cnt_q <= '0;
            fe_vld_q   <= 1'b0;
            fe_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            rem_q      <= rem_d;
            wb_addr_q  <= wb_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err1_cnt_q <= err1_cnt_d;
            err2_cnt_q <= err2_cnt_d;
            fe_vld_q   <= fe_vld_d;
            fe_addr_q  <= fe_addr_d;
        end
    end

    assign bus.rd_en_o          = rd_en_q;
    assign bus.rd_addr_o        = rd_addr_q;
    assign bus.wb_en_o          = wb_en;
    assign bus.wb_addr_o        = wb_addr_q;
    assign bus.busy_o           = busy_q;
    assign bus.done_o           = done_q;
    assign bus.err1_cnt_o       = err1_cnt_q;
    assign bus.err2_cnt_o       = err2_cnt_q;
    assign bus.first_err_vld_o  = fe_vld_q;
    assign bus.first_err_addr_o = fe_addr_q;
endmodule

// File: tb/tb_pe_run_ctrl.sv
// Bench for pe_run_ctrl: directed scenarios plus random traffic against a cycle-indexed run model.
module tb_pe_run_ctrl;
    localparam int DN  = 16;
    localparam int PL  = 3;
    localparam int EW  = 8;
    localparam int EWS = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pe_run_ctrl_if #(.DATA_NUM(DN), .ERR_CNT_W(EW))  bus   ();
    pe_run_ctrl_if #(.DATA_NUM(DN), .ERR_CNT_W(EWS)) bus_s ();

    assign bus_s.start_i = bus.start_i;
    assign bus_s.abort_i = bus.abort_i;
    assign bus_s.len_i   = bus.len_i;
    assign bus_s.err1_i  = bus.err1_i;
    assign bus_s.err2_i  = bus.err2_i;

    pe_run_ctrl #(.DATA_NUM(DN), .PIPE_LAT(PL), .ERR_CNT_W(EW)) dut (
        .clk (clk), .rst (rst), .bus (bus.slave)
    );

    // Narrow-counter copy so saturation is reachable within a single run.
    pe_run_ctrl #(.DATA_NUM(DN), .PIPE_LAT(PL), .ERR_CNT_W(EWS)) dut_sat (
        .clk (clk), .rst (rst), .bus (bus_s.slave)
    );

    int errors = 0;
    int checks = 0;

    // Run model: m_t is the cycle index since the start edge (cycle 1 = first read).
    int m_run, m_t, m_len, m_e1, m_e2, m_fv, m_fa, m_rd_addr, m_wb_addr;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic int wb_addr_at(input int t, input int len);
        if (t <= PL)            return 0;
        else if (t <= len + PL) return (t - 1 - PL) % DN;
        else                    return len % DN;
    endfunction

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_clear();
        m_run = 0; m_t = 0; m_len = 0; m_e1 = 0; m_e2 = 0;
        m_fv = 0; m_fa = 0; m_rd_addr = 0; m_wb_addr = 0;
    endtask

    task automatic model_step(input logic s, input logic a, input int l, input logic x1, input logic x2);
        if (m_run == 0) begin
            if (s && !a) begin
                m_run = 1; m_t = 1;
                m_len = ((l == 0) || (l > DN)) ? DN : l;
                m_e1 = 0; m_e2 = 0; m_fv = 0; m_fa = 0;
            end
        end else if (a) begin
            m_run = 0; m_t = 0;
        end else begin
            if ((m_t >= 2) && (m_t <= m_len + PL)) begin
                if (x1) m_e1++;
                if (x2) m_e2++;
                if ((x1 || x2) && (m_fv == 0)) begin
                    m_fv = 1;
                    m_fa = wb_addr_at(m_t, m_len);
                end
            end
            if (m_t == m_len + PL + 1) begin
                m_run = 0; m_t = 0;
            end else begin
                m_t++;
            end
        end
    endtask

    task automatic check_all();
        int rd_en, wb_en, busy, done;
        rd_en = 0; wb_en = 0; busy = 0; done = 0;
        if (m_run != 0) begin
            rd_en     = (m_t <= m_len) ? 1 : 0;
            wb_en     = ((m_t >= PL + 1) && (m_t <= m_len + PL)) ? 1 : 0;
            busy      = 1;
            done      = (m_t == m_len + PL + 1) ? 1 : 0;
            m_rd_addr = (((m_t <= m_len) ? m_t : m_len) - 1) % DN;
            m_wb_addr = wb_addr_at(m_t, m_len);
        end
        chk("rd_en",     bus.rd_en_o,          rd_en);
        chk("rd_addr",   bus.rd_addr_o,        m_rd_addr);
        chk("wb_en",     bus.wb_en_o,          wb_en);
        chk("wb_addr",   bus.wb_addr_o,        m_wb_addr);
        chk("busy",      bus.busy_o,           busy);
        chk("done",      bus.done_o,           done);
        chk("err1_cnt",  bus.err1_cnt_o,       sat(m_e1, EW));
        chk("err2_cnt",  bus.err2_cnt_o,       sat(m_e2, EW));
        chk("fe_vld",    bus.first_err_vld_o,  m_fv);
        chk("fe_addr",   bus.first_err_addr_o, m_fa);
        chk("err1_sat4", bus_s.err1_cnt_o,     sat(m_e1, EWS));
        chk("err2_sat4", bus_s.err2_cnt_o,     sat(m_e2, EWS));
    endtask

    task automatic cyc(input logic s, input logic a, input int l, input logic x1, input logic x2);
        @(negedge clk);
        check_all();
        bus.start_i = s;
        bus.abort_i = a;
        bus.len_i   = 5'(l);
        bus.err1_i  = x1;
        bus.err2_i  = x2;
        @(posedge clk);
        model_step(s, a, l, x1, x2);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic run(input int l, input int n);
        cyc(1'b1, 1'b0, l, 1'b0, 1'b0);
        idle(n);
    endtask

    initial begin
        bus.start_i = 1'b0; bus.abort_i = 1'b0; bus.len_i = '0;
        bus.err1_i = 1'b0;  bus.err2_i = 1'b0;
        model_clear();
        #1 rst = 1'b1;
        #1 check_all();
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // full run, len variants and boundary lengths
        run(16, 22);
        run(0, 22);
        run(17, 22);
        run(1, 6);
        run(31, 22);

        // error capture window; cycle-30 pulse falls in IDLE
        cyc(1'b1, 1'b0, 8, 1'b0, 1'b0);
        for (int t = 1; t <= 35; t++)
            cyc(1'b0, 1'b0, 0, (t == 9) || (t == 10) || (t == 30), t == 6);
        #2;
        chk("t3_err1", bus.err1_cnt_o, 2);
        chk("t3_err2", bus.err2_cnt_o, 1);
        chk("t3_fe_vld", bus.first_err_vld_o, 1);
        chk("t3_fe_addr", bus.first_err_addr_o, 2);

        // abort on cycle 5, then a clean run
        cyc(1'b1, 1'b0, 16, 1'b0, 1'b0);
        for (int t = 1; t <= 10; t++) cyc(1'b0, t == 5, 0, 1'b0, 1'b0);
        run(16, 22);

        // start re-pulsed mid-run is ignored; start+abort in IDLE does nothing
        cyc(1'b1, 1'b0, 8, 1'b0, 1'b0);
        for (int t = 1; t <= 14; t++) cyc(t == 7, 1'b0, 3, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 5, 1'b0, 1'b0);
        idle(3);
        #2 chk("start_abort_busy", bus.busy_o, 0);
        cyc(1'b0, 1'b1, 0, 1'b0, 1'b0);
        idle(2);

        // err1 held across a whole run and beyond
        cyc(1'b1, 1'b0, 16, 1'b1, 1'b0);
        for (int t = 1; t <= 25; t++) cyc(1'b0, 1'b0, 0, 1'b1, 1'b0);
        #2;
        chk("sat_err1_w8", bus.err1_cnt_o, 18);
        chk("sat_err1_w4", bus_s.err1_cnt_o, 15);

        // random traffic
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 63) == 0, $urandom_range(0, 31),
                $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);

        // reset in the middle of a run
        cyc(1'b1, 1'b0, 16, 1'b0, 1'b0);
        idle(6);
        #2;
        bus.start_i = 1'b0; bus.abort_i = 1'b0; bus.len_i = '0;
        bus.err1_i = 1'b0;  bus.err2_i = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_rd_en", bus.rd_en_o, 0);
        chk("rst_wb_en", bus.wb_en_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_rd_addr", bus.rd_addr_o, 0);
        model_clear();
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        idle(25);
        run(4, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
